// File: rtl/or1k_irq_sched_pkg.sv
// Shared types and constants for the OR1K interrupt scheduler.
// Build option OR1K_IRQ_SCHED_NESTING_EN is consumed by or1k_irq_sched.
package or1k_irq_sched_pkg;

   localparam int unsigned IRQ_ID_WIDTH = 5;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      SERVICE,
      HOLDOFF
   } irq_state_e;

endpackage

// File: rtl/or1k_irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins, valid flags any bit set.
module or1k_irq_prio_enc
   import or1k_irq_sched_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0]        vec_i,
   output logic                    valid_o,
   output logic [IRQ_ID_WIDTH-1:0] idx_o
);

   always_comb begin
      valid_o = |vec_i;
      idx_o   = '0;
      // Scan downwards so the lowest set index is the last one written.
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
         if (vec_i[i]) idx_o = IRQ_ID_WIDTH'(i);
      end
   end

endmodule

// File: rtl/or1k_irq_sched.sv
// Interrupt scheduler between the OR1K PIC and the core: request, service, holdoff.
// Define OR1K_IRQ_SCHED_NESTING_EN to allow higher-priority lines to preempt SERVICE.
module or1k_irq_sched
   import or1k_irq_sched_pkg::*;
#(
   parameter int unsigned IRQ_WIDTH      = 32,
   parameter int unsigned HOLDOFF_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [IRQ_WIDTH-1:0]    picsr_i,
   output logic                    irq_req_o,
   output logic [IRQ_ID_WIDTH-1:0] irq_id_o,
   input  logic                    irq_ack_i,
   input  logic                    eoi_i,
   output logic [IRQ_WIDTH-1:0]    isr_o,
   output logic                    busy_o
);

   localparam int unsigned CNT_WIDTH =
      (HOLDOFF_CYCLES == 0) ? 1 : $clog2(HOLDOFF_CYCLES + 1);

   irq_state_e              state_q, state_d;
   logic [IRQ_WIDTH-1:0]    isr_q, isr_d;
   logic [IRQ_ID_WIDTH-1:0] id_q, id_d;
   logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
   logic                    req_q;

   logic [IRQ_WIDTH-1:0]    pend;
   logic [IRQ_WIDTH-1:0]    id_onehot;
   logic                    id_pending;
   logic                    pend_valid, isr_valid;
   logic [IRQ_ID_WIDTH-1:0] pend_idx, isr_idx;

   assign pend       = picsr_i & ~isr_q;
   assign id_onehot  = IRQ_WIDTH'(1) << id_q;
   assign id_pending = |(picsr_i & id_onehot);

   or1k_irq_prio_enc #(.WIDTH(IRQ_WIDTH)) u_pend_enc (
      .vec_i   (pend),
      .valid_o (pend_valid),
      .idx_o   (pend_idx)
   );

   or1k_irq_prio_enc #(.WIDTH(IRQ_WIDTH)) u_isr_enc (
      .vec_i   (isr_q),
      .valid_o (isr_valid),
      .idx_o   (isr_idx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         isr_q   <= '0;
         id_q    <= '0;
         cnt_q   <= '0;
         req_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         isr_q   <= isr_d;
         id_q    <= id_d;
         cnt_q   <= cnt_d;
         req_q   <= (state_d == REQ);
      end
   end

   always_comb begin
      state_d = state_q;
      isr_d   = isr_q;
      id_d    = id_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (pend_valid) begin
               state_d = REQ;
               id_d    = pend_idx;
            end
         end
         REQ: begin
            // Ack wins over a simultaneous withdraw; a withdrawn nested request resumes service.
            if (irq_ack_i) begin
               isr_d   = isr_q | id_onehot;
               state_d = SERVICE;
            end else if (!id_pending) begin
               state_d = (isr_q != '0) ? SERVICE : IDLE;
            end
         end
         SERVICE: begin
            if (eoi_i && isr_valid) isr_d = isr_q & ~(IRQ_WIDTH'(1) << isr_idx);
            if (isr_d == '0) begin
               if (HOLDOFF_CYCLES > 0) begin
                  state_d = HOLDOFF;
                  cnt_d   = CNT_WIDTH'(HOLDOFF_CYCLES);
               end else begin
                  state_d = IDLE;
               end
            end
`ifdef OR1K_IRQ_SCHED_NESTING_EN
            else if (pend_valid && (pend_idx < isr_idx)) begin
               state_d = REQ;
               id_d    = pend_idx;
            end
`endif
         end
         HOLDOFF: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q <= CNT_WIDTH'(1)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      irq_req_o = req_q;
      irq_id_o  = id_q;
      isr_o     = isr_q;
      busy_o    = (state_q != IDLE);
   end

endmodule

// File: tb/tb_or1k_irq_sched.sv
// Scoreboard bench for or1k_irq_sched against a cycle-level behavioural model.
module tb_or1k_irq_sched;
   import or1k_irq_sched_pkg::*;

   localparam int unsigned W = 32;
   localparam int unsigned H = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [W-1:0]    picsr = '0;
   logic            ack = 1'b0;
   logic            eoi = 1'b0;
   logic            irq_req;
   logic [4:0]      irq_id;
   logic [W-1:0]    isr;
   logic            busy;

   typedef struct packed {
      logic         req;
      logic [4:0]   id;
      logic [W-1:0] isr;
      logic         busy;
   } obs_t;

   obs_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   // Model: requesting flag, latched id, in-service mask, remaining holdoff cycles.
   bit           m_requesting;
   int           m_id;
   logic [W-1:0] m_isr;
   int           m_hold;

   or1k_irq_sched #(.IRQ_WIDTH(W), .HOLDOFF_CYCLES(H)) dut (
      .clk       (clk),
      .rst       (rst),
      .picsr_i   (picsr),
      .irq_req_o (irq_req),
      .irq_id_o  (irq_id),
      .irq_ack_i (ack),
      .eoi_i     (eoi),
      .isr_o     (isr),
      .busy_o    (busy)
   );

   always #5 clk = ~clk;

   function automatic int lowest(input logic [W-1:0] v);
      for (int i = 0; i < int'(W); i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_requesting = 1'b0;
      m_id         = 0;
      m_isr        = '0;
      m_hold       = 0;
   endtask

   task automatic model_step();
      int lo_pend;
      int lo_isr;
      lo_pend = lowest(picsr & ~m_isr);
      lo_isr  = lowest(m_isr);
      if (m_requesting) begin
         if (ack) begin
            m_isr[m_id]  = 1'b1;
            m_requesting = 1'b0;
         end else if (!picsr[m_id]) begin
            m_requesting = 1'b0;
         end
      end else if (m_isr != '0) begin
         if (eoi) begin
            m_isr = m_isr & (m_isr - 1);
            if (m_isr == '0) m_hold = H;
         end
`ifdef OR1K_IRQ_SCHED_NESTING_EN
         if (m_isr != '0 && lo_pend >= 0 && lo_pend < lo_isr) begin
            m_requesting = 1'b1;
            m_id         = lo_pend;
         end
`endif
      end else if (m_hold > 0) begin
         m_hold--;
      end else if (lo_pend >= 0) begin
         m_requesting = 1'b1;
         m_id         = lo_pend;
      end
   endtask

   task automatic tick();
      obs_t e;
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      e.req  = m_requesting;
      e.id   = 5'(m_id);
      e.isr  = m_isr;
      e.busy = m_requesting || (m_isr != '0) || (m_hold > 0);
      exp_q.push_back(e);
      #1;
   endtask

   task automatic run(input logic [W-1:0] p, input logic a, input logic e, input int n);
      picsr = p;
      ack   = a;
      eoi   = e;
      repeat (n) tick();
   endtask

   // Assert reset mid-cycle and check outputs clear without waiting for an edge.
   task automatic do_reset();
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      tests++;
      if ({irq_req, irq_id, isr, busy} !== '0) begin
         fails++;
         $display("FAIL async_reset got req=%0b id=%0d isr=%h busy=%0b required all zero",
                  irq_req, irq_id, isr, busy);
      end
      tick();
      rst = 1'b0;
   endtask

   always @(negedge clk) begin : monitor
      obs_t e;
      obs_t got;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         got = {irq_req, irq_id, isr, busy};
         tests++;
         if (got !== e) begin
            fails++;
            $display("FAIL scoreboard t=%0t got req=%0b id=%0d isr=%h busy=%0b required req=%0b id=%0d isr=%h busy=%0b",
                     $time, got.req, got.id, got.isr, got.busy, e.req, e.id, e.isr, e.busy);
         end
      end
   end

   initial begin
      logic [W-1:0] p;
      model_reset();
      repeat (2) tick();
      rst = 1'b0;

      // Basic request, three REQ cycles, ack, eoi, holdoff.
      run(32'h14, 1'b0, 1'b0, 3);
      run(32'h14, 1'b1, 1'b0, 1);
      run(32'h14, 1'b0, 1'b0, 2);
      run(32'h0,  1'b0, 1'b1, 1);
      run(32'h0,  1'b0, 1'b0, 6);
      // Withdraw before ack.
      run(32'h8,  1'b0, 1'b0, 2);
      run(32'h0,  1'b0, 1'b0, 3);
      // Ack coincident with withdraw.
      run(32'h8,  1'b0, 1'b0, 2);
      run(32'h0,  1'b1, 1'b0, 1);
      run(32'h0,  1'b0, 1'b1, 1);
      run(32'h0,  1'b0, 1'b0, 6);
      // eoi with the line still pending: holdoff, then re-request.
      run(32'h2,  1'b0, 1'b0, 2);
      run(32'h2,  1'b1, 1'b0, 1);
      run(32'h2,  1'b0, 1'b1, 1);
      run(32'h2,  1'b0, 1'b0, 8);
      run(32'h2,  1'b1, 1'b0, 1);
      run(32'h0,  1'b0, 1'b1, 1);
      run(32'h0,  1'b0, 1'b0, 6);
      // Line 5 in service, line 0 raised.
      run(32'h20, 1'b0, 1'b0, 2);
      run(32'h20, 1'b1, 1'b0, 1);
      run(32'h21, 1'b0, 1'b0, 3);
      run(32'h21, 1'b1, 1'b0, 1);
      run(32'h1,  1'b0, 1'b1, 1);
      run(32'h1,  1'b0, 1'b0, 2);
      run(32'h0,  1'b0, 1'b1, 1);
      run(32'h0,  1'b1, 1'b0, 2);
      run(32'h0,  1'b0, 1'b1, 1);
      run(32'h0,  1'b0, 1'b0, 8);
      // Reset mid-service with line 4, then re-request.
      run(32'h10, 1'b0, 1'b0, 2);
      run(32'h10, 1'b1, 1'b0, 1);
      run(32'h10, 1'b0, 1'b0, 2);
      do_reset();
      run(32'h10, 1'b0, 1'b0, 3);

      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 7) == 0) begin
            p = '0;
            repeat ($urandom_range(0, 2)) p[$urandom_range(0, 7)] = 1'b1;
            if ($urandom_range(0, 15) == 0) p[31] = 1'b1;
            picsr = p;
         end
         ack = ($urandom_range(0, 2) == 0);
         eoi = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 499) == 0) do_reset();
         else tick();
      end

      repeat (2) @(negedge clk);
      #1;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain got %0d pending expectations required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
